// File: rtl/mapache64_pkg.sv
// Shared types for the mapache64 controller path: button layout and device-side FSM states.
package mapache64;

    typedef logic [7:0] data_t;
    typedef logic [7:0] controller_buttons_t;

    localparam int unsigned BUTTON_A      = 0;
    localparam int unsigned BUTTON_B      = 1;
    localparam int unsigned BUTTON_SELECT = 2;
    localparam int unsigned BUTTON_START  = 3;
    localparam int unsigned BUTTON_UP     = 4;
    localparam int unsigned BUTTON_DOWN   = 5;
    localparam int unsigned BUTTON_LEFT   = 6;
    localparam int unsigned BUTTON_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SHIFT,
        DRAIN
    } controller_dev_state_t;

endpackage

// File: rtl/controller_device_sync_edge.sv
// Multi-flop synchronizer plus history flop for one asynchronous host pin.
// Reset loads the pin's idle level into every flop so leaving reset never produces an edge.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/controller_device.sv
// Responder side of the NES-style serial pad protocol: latches buttons_i on the host latch
// and shifts them out active-low on host clock rises, bit0 first.
module controller_device
    import mapache64::*;
#(
    parameter int unsigned BUTTON_WIDTH = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bit          FILL_PRESSED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUTTON_WIDTH-1:0] buttons_i,
    input  logic                    controller_clk_i,
    input  logic                    controller_latch_i,
    output logic                    serial_no,
    output logic                    busy_o,
    output logic                    snapshot_o,
    output logic                    frame_done_o,
    output logic [7:0]              frame_count_o
);

    localparam int unsigned CNT_W = $clog2(BUTTON_WIDTH) + 1;
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(BUTTON_WIDTH - 2);

    controller_dev_state_t r_state;
    controller_dev_state_t w_state_next;

    logic [BUTTON_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_serial_no;
    logic                    r_snapshot;
    logic                    r_frame_done;
    logic [7:0]              r_frame_count;

    logic w_clk_level, w_clk_rise, w_clk_fall;
    logic w_latch_level, w_latch_rise, w_latch_fall;
    logic w_last_shift;
    logic w_serial_next;
    logic w_busy;
    logic w_unused;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .i_async (controller_clk_i),
        .o_level (w_clk_level),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_latch (
        .clk     (clk),
        .rst     (rst),
        .i_async (controller_latch_i),
        .o_level (w_latch_level),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    assign w_unused     = ^{w_clk_level, w_clk_fall, w_latch_level};
    assign w_last_shift = w_clk_rise && (r_bit_cnt == PRE_LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A latch rise aborts whatever is in flight, including a coincident clock rise.
    always_comb begin
        w_state_next = r_state;
        if (w_latch_rise) begin
            w_state_next = LATCH;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                LATCH:   if (w_latch_fall) w_state_next = SHIFT;
                SHIFT:   if (w_last_shift) w_state_next = DRAIN;
                DRAIN:   w_state_next = DRAIN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy        = (r_state == LATCH) || (r_state == SHIFT);
        w_serial_next = (r_state == IDLE) ? 1'b1 : ~r_shreg[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_serial_no   <= 1'b1;
            r_snapshot    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_snapshot   <= 1'b0;
            r_frame_done <= 1'b0;
            r_serial_no  <= w_serial_next;
            if (!w_latch_rise) begin
                case (r_state)
                    LATCH: begin
                        r_shreg <= buttons_i;
                        if (w_latch_fall) begin
                            r_bit_cnt  <= '0;
                            r_snapshot <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (w_clk_rise) begin
                            r_shreg   <= {FILL_PRESSED, r_shreg[BUTTON_WIDTH-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_shift) begin
                                r_frame_done  <= 1'b1;
                                r_frame_count <= r_frame_count + 8'd1;
                            end
                        end
                    end
                    // The last bit stays exposed until the next rise; later rises only push fill.
                    DRAIN: begin
                        if (w_clk_rise) begin
                            r_shreg <= {FILL_PRESSED, r_shreg[BUTTON_WIDTH-1:1]};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign serial_no     = r_serial_no;
    assign busy_o        = w_busy;
    assign snapshot_o    = r_snapshot;
    assign frame_done_o  = r_frame_done;
    assign frame_count_o = r_frame_count;

endmodule

// File: tb/tb_controller_device.sv
// Scoreboard bench for controller_device: stimulus pushes expected serial samples and frame
// counts into queues, independent monitors pop and compare when the DUT presents them.
module tb_controller_device;
    import mapache64::*;

    localparam int unsigned BW = 8;
    localparam int unsigned PH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] buttons_i = 8'h00;
    logic       controller_clk_i = 1'b1;
    logic       controller_latch_i = 1'b0;

    logic       serial_no, busy_o, snapshot_o, frame_done_o;
    logic [7:0] frame_count_o;
    logic       serial_no_f0, busy_f0, snapshot_f0, frame_done_f0;
    logic [7:0] frame_count_f0;

    controller_device #(
        .BUTTON_WIDTH (BW),
        .SYNC_STAGES  (2),
        .FILL_PRESSED (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .buttons_i          (buttons_i),
        .controller_clk_i   (controller_clk_i),
        .controller_latch_i (controller_latch_i),
        .serial_no          (serial_no),
        .busy_o             (busy_o),
        .snapshot_o         (snapshot_o),
        .frame_done_o       (frame_done_o),
        .frame_count_o      (frame_count_o)
    );

    controller_device #(
        .BUTTON_WIDTH (BW),
        .SYNC_STAGES  (2),
        .FILL_PRESSED (1'b0)
    ) dut_f0 (
        .clk                (clk),
        .rst                (rst),
        .buttons_i          (buttons_i),
        .controller_clk_i   (controller_clk_i),
        .controller_latch_i (controller_latch_i),
        .serial_no          (serial_no_f0),
        .busy_o             (busy_f0),
        .snapshot_o         (snapshot_f0),
        .frame_done_o       (frame_done_f0),
        .frame_count_o      (frame_count_f0)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sample_q[$];   // {expected FILL=1 serial, expected FILL=0 serial}
    logic [7:0] done_q[$];
    int         snap_q[$];
    bit         sample_en = 1'b0;
    bit         toggle_en = 1'b0;
    logic [7:0] exp_count = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k, input logic fill);
        return (k < int'(BW)) ? ~b[k] : ~fill;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_pulse(input int ph, input logic [7:0] b, input int k, input bit smp);
        if (smp) sample_q.push_back({exp_bit(b, k, 1'b1), exp_bit(b, k, 1'b0)});
        sample_en = smp;
        controller_clk_i = 1'b0;
        wait_cyc(ph);
        controller_clk_i = 1'b1;
        wait_cyc(ph);
    endtask

    task automatic latch_pulse(input logic [7:0] b, input int ph);
        buttons_i = b;
        controller_latch_i = 1'b1;
        wait_cyc(ph);
        snap_q.push_back(1);
        controller_latch_i = 1'b0;
        wait_cyc(ph);
    endtask

    // Full frame: 8 sampled clock pulses (7 shifting rises + 1 ignored), count bumps on rise 7.
    task automatic full_frame(input logic [7:0] b, input int extra);
        latch_pulse(b, PH);
        for (int k = 0; k < int'(BW) + extra; k++) begin
            if (k == int'(BW) - 2) begin
                exp_count = exp_count + 8'd1;
                done_q.push_back(exp_count);
            end
            clk_pulse(PH, b, k, 1'b1);
        end
    endtask

    // Serial monitor: host samples data just after it drives its clock low.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge controller_clk_i);
            if (sample_en) begin
                #1;
                if (sample_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample_underflow: got sample with empty queue required none");
                end else begin
                    e = sample_q.pop_front();
                    check("serial_no", {31'd0, serial_no}, {31'd0, e[1]});
                    check("serial_no_fill0", {31'd0, serial_no_f0}, {31'd0, e[0]});
                end
            end
        end
    end

    // Pulse monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (frame_done_o) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_done: got pulse count=%0d required none",
                                 frame_count_o);
                    end else begin
                        check("frame_count_at_done", {24'd0, frame_count_o},
                              {24'd0, done_q.pop_front()});
                    end
                end
                if (snapshot_o) begin
                    if (snap_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_snapshot: got pulse required none");
                    end else begin
                        void'(snap_q.pop_front());
                        check("busy_at_snapshot", {31'd0, busy_o}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (toggle_en) buttons_i = ~buttons_i;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        wait_cyc(4);
        check("rst_serial", {31'd0, serial_no}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_count", {24'd0, frame_count_o}, 32'd0);
        check("rst_done", {31'd0, frame_done_o}, 32'd0);
        check("rst_snapshot", {31'd0, snapshot_o}, 32'd0);
        check("rst_serial_fill0", {31'd0, serial_no_f0}, 32'd1);
        rst = 1'b0;
        wait_cyc(6);
        check("idle_busy", {31'd0, busy_o}, 32'd0);
        check("idle_serial", {31'd0, serial_no}, 32'd1);

        // Basic frame plus drain behaviour for both fill settings
        full_frame(8'hA5, 4);
        check("count_frame1", {24'd0, frame_count_o}, 32'd1);
        check("drain_busy", {31'd0, busy_o}, 32'd0);

        // Abort after 3 shifts, then a full 0xFF frame
        latch_pulse(8'h0F, PH);
        for (int k = 0; k < 3; k++) clk_pulse(PH, 8'h0F, k, 1'b1);
        buttons_i = 8'hFF;
        controller_latch_i = 1'b1;
        for (int i = 0; i < int'(PH); i++) begin
            @(negedge clk);
            check("abort_busy", {31'd0, busy_o}, 32'd1);
        end
        check("abort_count", {24'd0, frame_count_o}, 32'd1);
        snap_q.push_back(1);
        controller_latch_i = 1'b0;
        wait_cyc(PH);
        for (int k = 0; k < int'(BW); k++) begin
            if (k == int'(BW) - 2) begin
                exp_count = exp_count + 8'd1;
                done_q.push_back(exp_count);
            end
            clk_pulse(PH, 8'hFF, k, 1'b1);
        end
        check("count_frame2", {24'd0, frame_count_o}, 32'd2);

        // Buttons toggling during the shift must not disturb the snapshot
        latch_pulse(8'h3C, PH);
        toggle_en = 1'b1;
        for (int k = 0; k < int'(BW); k++) begin
            if (k == int'(BW) - 2) begin
                exp_count = exp_count + 8'd1;
                done_q.push_back(exp_count);
            end
            clk_pulse(PH, 8'h3C, k, 1'b1);
        end
        toggle_en = 1'b0;
        check("count_frame3", {24'd0, frame_count_o}, 32'd3);

        // Coincident latch rise + clock rise, then latch fall + clock rise
        latch_pulse(8'hC3, PH);
        clk_pulse(PH, 8'hC3, 0, 1'b1);
        clk_pulse(PH, 8'hC3, 1, 1'b1);
        sample_q.push_back({exp_bit(8'hC3, 2, 1'b1), exp_bit(8'hC3, 2, 1'b0)});
        sample_en = 1'b1;
        controller_clk_i = 1'b0;
        wait_cyc(PH);
        buttons_i = 8'h6A;
        controller_clk_i = 1'b1;
        controller_latch_i = 1'b1;
        wait_cyc(PH);
        check("coincident_rise_busy", {31'd0, busy_o}, 32'd1);
        check("coincident_rise_count", {24'd0, frame_count_o}, 32'd3);
        sample_q.push_back({exp_bit(8'h6A, 0, 1'b1), exp_bit(8'h6A, 0, 1'b0)});
        controller_clk_i = 1'b0;
        wait_cyc(PH);
        snap_q.push_back(1);
        controller_clk_i = 1'b1;
        controller_latch_i = 1'b0;
        wait_cyc(PH);
        for (int k = 0; k < int'(BW); k++) begin
            if (k == int'(BW) - 2) begin
                exp_count = exp_count + 8'd1;
                done_q.push_back(exp_count);
            end
            clk_pulse(PH, 8'h6A, k, 1'b1);
        end
        check("count_frame4", {24'd0, frame_count_o}, 32'd4);

        // Reset mid-shift
        latch_pulse(8'h81, PH);
        for (int k = 0; k < 3; k++) clk_pulse(PH, 8'h81, k, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_serial", {31'd0, serial_no}, 32'd1);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_count", {24'd0, frame_count_o}, 32'd0);
        rst = 1'b0;
        exp_count = 8'd0;
        for (int k = 0; k < 2; k++) clk_pulse(PH, 8'h81, k, 1'b0);
        check("postrst_busy", {31'd0, busy_o}, 32'd0);
        check("postrst_serial", {31'd0, serial_no}, 32'd1);

        // 256 short frames wrap the counter back to 0
        for (int f = 0; f < 256; f++) begin
            latch_pulse(8'(f), 4);
            for (int k = 0; k < int'(BW) - 1; k++) begin
                if (k == int'(BW) - 2) begin
                    exp_count = exp_count + 8'd1;
                    done_q.push_back(exp_count);
                end
                clk_pulse(4, 8'(f), k, 1'b0);
            end
            if (f == 254) check("count_before_wrap", {24'd0, frame_count_o}, 32'd255);
        end
        check("count_wrapped", {24'd0, frame_count_o}, 32'd0);
        check("count_wrapped_fill0", {24'd0, frame_count_f0}, 32'd0);

        wait_cyc(10);
        check("sample_q_drained", sample_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);
        check("snap_q_drained", snap_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
